// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: shared state, opcode, ALU and mux-select encodings for the multi-cycle control unit.
package multicycle_control_unit_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS1 = 2'b01, SRCA_OLD_PC = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10;
  localparam logic [1:0] WBSEL_ALU = 2'b00, WBSEL_MEM = 2'b01, WBSEL_PC4 = 2'b10;
endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// alu_op_decoder: maps funct3/funct7 of R- and I-type instructions to an ALU operation plus an illegal flag.
module alu_op_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  input  logic                  i_is_imm,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_illegal
);
  logic [3:0] w_op;
  logic       w_ill;
  always_comb begin
    w_op  = ALU_ADD;
    w_ill = 1'b0;
    case (i_funct3)
      3'b000:  w_op = (!i_is_imm && i_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b001:  w_op = ALU_SLL;
      3'b010:  begin w_op = ALU_SLT; w_ill = i_is_imm; end
      3'b100:  w_op = ALU_XOR;
      3'b101:  begin w_op = ALU_SRL; w_ill = i_is_imm; end
      3'b110:  w_op = ALU_OR;
      3'b111:  w_op = ALU_AND;
      default: w_ill = 1'b1;
    endcase
    // only SUB uses the alternate funct7 encoding; immediates ignore funct7
    if (!i_is_imm && i_funct7 != 7'b0 && !(i_funct7 == F7_ALT && i_funct3 == 3'b000)) w_ill = 1'b1;
  end
  assign o_illegal     = w_ill;
  assign o_alu_control = w_ill ? '0 : ALU_CTRL_W'(w_op);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle RV32I datapath.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4,
  parameter int ENABLE_JALR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [1:0]            mem_size,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  branch_ne,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  illegal_instr,
  output logic                  timeout
);
  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [2:0]            r_funct3;
  logic [6:0]            r_funct7;
  logic                  r_is_store, r_ill, r_to;
  state_t                w_dec_next, w_next;
  logic [ALU_CTRL_W-1:0] w_alu;
  logic                  w_alu_ill, w_mem, w_expire, w_size_ok, w_br_ok;
  alu_op_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .i_funct3     (r_funct3),
    .i_funct7     (r_funct7),
    .i_is_imm     (r_state == S_EXEC_I),
    .o_alu_control(w_alu),
    .o_illegal    (w_alu_ill)
  );
  assign w_mem     = r_state == S_FETCH || r_state == S_MEM_RD || r_state == S_MEM_WR;
  assign w_expire  = w_mem && !mem_ready && r_cnt == 8'(MEM_TIMEOUT - 1);
  assign w_size_ok = r_funct3 == 3'b000 || r_funct3 == 3'b010;
  assign w_br_ok   = r_funct3[2:1] == 2'b00;
  always_comb begin
    case (opcode)
      OP_R:              w_dec_next = S_EXEC_R;
      OP_I:              w_dec_next = S_EXEC_I;
      OP_LOAD, OP_STORE: w_dec_next = S_MEM_ADDR;
      OP_BRANCH:         w_dec_next = S_BRANCH;
      OP_JAL:            w_dec_next = S_JAL;
      OP_JALR:           w_dec_next = (ENABLE_JALR != 0) ? S_JALR : S_TRAP;
      default:           w_dec_next = S_TRAP;
    endcase
  end
  always_comb begin
    case (r_state)
      S_FETCH:            w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:           w_next = w_dec_next;
      S_EXEC_R, S_EXEC_I: w_next = w_alu_ill ? S_TRAP : S_WB_ALU;
      S_MEM_ADDR:         w_next = !w_size_ok ? S_TRAP : r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:           w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:           w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:           w_next = w_br_ok ? S_FETCH : S_TRAP;
      S_TRAP:             w_next = S_TRAP;
      default:            w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_cnt      <= '0;
      r_ill      <= 1'b0;
      r_to       <= 1'b0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_cnt <= (w_mem && !mem_ready) ? r_cnt + 8'd1 : '0;
      if (w_expire) begin
        r_state <= S_TRAP;
        r_to    <= 1'b1;
      end else begin
        r_state <= w_next;
        if (w_next == S_TRAP && r_state != S_TRAP) r_ill <= 1'b1;
      end
      if (r_state == S_DECODE) begin
        r_funct3   <= funct3;
        r_funct7   <= funct7;
        r_is_store <= opcode == OP_STORE;
      end
    end
  end
  // every decoded output is held low while reset is asserted, whatever the state
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_size      = 2'b00;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_control   = ALU_CTRL_W'(ALU_ADD);
    reg_write     = 1'b0;
    wb_sel        = WBSEL_ALU;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
        end
        S_EXEC_R: begin
          alu_src_a   = SRCA_RS1;
          alu_control = w_alu;
        end
        S_EXEC_I: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          alu_control = w_alu;
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD, S_MEM_WR: begin
          mem_req  = 1'b1;
          i_or_d   = 1'b1;
          mem_we   = r_state == S_MEM_WR;
          mem_size = r_funct3 == 3'b010 ? 2'b10 : 2'b00;
        end
        S_WB_ALU: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WBSEL_MEM;
        end
        S_BRANCH: begin
          alu_src_a     = SRCA_RS1;
          alu_control   = ALU_CTRL_W'(ALU_SUB);
          pc_write_cond = w_br_ok;
          branch_ne     = w_br_ok && r_funct3[0];
        end
        S_JAL: begin
          reg_write = 1'b1;
          wb_sel    = WBSEL_PC4;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          reg_write = 1'b1;
          wb_sel    = WBSEL_PC4;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign illegal_instr = rst_n && r_ill;
  assign timeout       = rst_n && r_to;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and randomized instruction streams checked against a per-instruction cycle model.
module tb_multicycle_control_unit;
  localparam int T = 4;
  typedef struct packed {
    logic req, we;
    logic [1:0] size;
    logic iod, irw, pcw, pcc, bne;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic rw;
    logic [1:0] wb;
    logic ill, to;
  } ov_t;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne, reg_write, illegal_instr, timeout;
  logic [1:0] mem_size, alu_src_a, alu_src_b, wb_sel;
  logic [3:0] alu_control;
  logic b_mem_req, b_mem_we, b_i_or_d, b_ir_write, b_pc_write, b_pc_write_cond, b_branch_ne, b_reg_write, b_illegal_instr, b_timeout;
  logic [1:0] b_mem_size, b_alu_src_a, b_alu_src_b, b_wb_sel;
  logic [3:0] b_alu_control;
  ov_t obs;
  int n_run = 0, n_fail = 0;
  bit m_ill, m_to, m_trap;
  always #5 clk = ~clk;
  multicycle_control_unit #(.MEM_TIMEOUT(T), .ALU_CTRL_W(4), .ENABLE_JALR(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal_instr(illegal_instr), .timeout(timeout));
  multicycle_control_unit #(.MEM_TIMEOUT(T), .ALU_CTRL_W(4), .ENABLE_JALR(0)) dut_nojalr (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_size(b_mem_size), .i_or_d(b_i_or_d), .ir_write(b_ir_write),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .branch_ne(b_branch_ne), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_control(b_alu_control), .reg_write(b_reg_write), .wb_sel(b_wb_sel),
    .illegal_instr(b_illegal_instr), .timeout(b_timeout));
  assign obs = {mem_req, mem_we, mem_size, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                alu_src_a, alu_src_b, alu_control, reg_write, wb_sel, illegal_instr, timeout};
  function automatic ov_t flags();
    ov_t e = '0;
    e.ill = m_ill;
    e.to  = m_to;
    return e;
  endfunction
  // returns {illegal, op} straight from the ALU encoding table
  function automatic logic [4:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7, input bit imm);
    if (imm) begin
      case (f3)
        3'b000: return {1'b0, 4'd0};
        3'b111: return {1'b0, 4'd2};
        3'b110: return {1'b0, 4'd3};
        3'b100: return {1'b0, 4'd4};
        3'b001: return {1'b0, 4'd5};
        default: return {1'b1, 4'd0};
      endcase
    end
    if (f7 == 7'b0100000) return (f3 == 3'b000) ? {1'b0, 4'd1} : {1'b1, 4'd0};
    if (f7 != 7'b0) return {1'b1, 4'd0};
    case (f3)
      3'b000: return {1'b0, 4'd0};
      3'b001: return {1'b0, 4'd5};
      3'b010: return {1'b0, 4'd7};
      3'b100: return {1'b0, 4'd4};
      3'b101: return {1'b0, 4'd6};
      3'b110: return {1'b0, 4'd3};
      3'b111: return {1'b0, 4'd2};
      default: return {1'b1, 4'd0};
    endcase
  endfunction
  task automatic chk(input string tag, input ov_t o, input ov_t e);
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic cyc(input bit rdy, input ov_t e, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    chk(tag, obs, e);
  endtask
  task automatic trap_cycles(input string tag);
    m_trap = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'($urandom_range(0, 1)), flags(), tag);
  endtask
  task automatic mem_phase(input ov_t e, input int waits, input string tag, output bit ok);
    ov_t w;
    ok = 1'b1;
    w = e;
    w.irw = 1'b0;
    w.pcw = 1'b0;
    for (int i = 0; i < waits; i++) begin
      cyc(1'b0, w, tag);
      if (i == T - 1) begin
        m_to = 1'b1;
        ok = 1'b0;
        return;
      end
    end
    cyc(1'b1, e, tag);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("reset", obs, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ill = 1'b0;
    m_to = 1'b0;
    m_trap = 1'b0;
  endtask
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input int fw, input int mw);
    ov_t e;
    bit ok;
    logic [4:0] a;
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    e = flags(); e.req = 1; e.sb = 2'b01; e.irw = 1; e.pcw = 1;
    mem_phase(e, fw, "fetch", ok);
    if (!ok) begin trap_cycles("fetch_timeout"); return; end
    e = flags(); e.sa = 2'b10; e.sb = 2'b10;
    cyc(1'($urandom_range(0, 1)), e, "decode");
    @(posedge clk);
    #1;
    opcode = 7'($urandom);
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    e = flags();
    case (op)
      7'b0110011, 7'b0010011: begin
        a = alu_ref(f3, f7, op == 7'b0010011);
        e.sa = 2'b01; e.sb = (op == 7'b0010011) ? 2'b10 : 2'b00; e.alu = a[3:0];
        cyc(1'($urandom_range(0, 1)), e, "exec");
        if (a[4]) begin m_ill = 1'b1; trap_cycles("exec_trap"); return; end
        e = flags(); e.rw = 1;
        cyc(1'($urandom_range(0, 1)), e, "wb_alu");
      end
      7'b0000011, 7'b0100011: begin
        e.sa = 2'b01; e.sb = 2'b10;
        cyc(1'($urandom_range(0, 1)), e, "mem_addr");
        if (f3 != 3'b000 && f3 != 3'b010) begin m_ill = 1'b1; trap_cycles("size_trap"); return; end
        e = flags(); e.req = 1; e.iod = 1; e.we = (op == 7'b0100011); e.size = (f3 == 3'b010) ? 2'b10 : 2'b00;
        mem_phase(e, mw, "mem_access", ok);
        if (!ok) begin trap_cycles("mem_timeout"); return; end
        if (op == 7'b0000011) begin
          e = flags(); e.rw = 1; e.wb = 2'b01;
          cyc(1'($urandom_range(0, 1)), e, "wb_mem");
        end
      end
      7'b1100011: begin
        e.sa = 2'b01; e.alu = 4'd1;
        if (f3 <= 3'b001) begin e.pcc = 1; e.bne = f3[0]; end
        cyc(1'($urandom_range(0, 1)), e, "branch");
        if (f3 > 3'b001) begin m_ill = 1'b1; trap_cycles("branch_trap"); end
      end
      7'b1101111: begin
        e.rw = 1; e.wb = 2'b10; e.pcw = 1;
        cyc(1'($urandom_range(0, 1)), e, "jal");
      end
      7'b1100111: begin
        e.sa = 2'b01; e.sb = 2'b10; e.rw = 1; e.wb = 2'b10; e.pcw = 1;
        cyc(1'($urandom_range(0, 1)), e, "jalr");
      end
      default: begin m_ill = 1'b1; trap_cycles("opcode_trap"); end
    endcase
  endtask
  initial begin
    logic [6:0] op, f7;
    logic [6:0] ops [8];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000};
    do_reset();
    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0);
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3);
    run_instr(7'b1100011, 3'b001, 7'b0000000, 0, 0);
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1, 0);
    run_instr(7'b0100011, 3'b000, 7'b0000000, 2, 1);
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0);
    run_instr(7'b0010011, 3'b110, 7'b1111111, 0, 0);
    run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0);
    run_instr(7'b0000011, 3'b000, 7'b0000000, T - 1, T - 1);
    run_instr(7'b0000000, 3'b000, 7'b0000000, 0, 0);
    do_reset();
    run_instr(7'b0110011, 3'b111, 7'b0000000, 0, 0);
    run_instr(7'b0110011, 3'b000, 7'b0000000, T, 0);
    do_reset();
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, T);
    do_reset();
    run_instr(7'b1100111, 3'b000, 7'b0000000, 0, 0);
    n_run++;
    assert ({b_illegal_instr, b_reg_write, b_pc_write, b_mem_req} === 4'b1000) else begin
      n_fail++;
      $error("FAIL jalr_disabled observed=%b expected=1000", {b_illegal_instr, b_reg_write, b_pc_write, b_mem_req});
    end
    do_reset();
    cyc(1'b0, '{req: 1, sb: 2'b01, default: '0}, "fetch_before_reset");
    do_reset();
    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'b0000000;
        2:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      run_instr(op, 3'($urandom), f7,
                ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, T - 1)),
                ($urandom_range(0, 15) == 0) ? T : int'($urandom_range(0, T - 1)));
      if (m_trap || $urandom_range(0, 19) == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
